// File: rtl/cuckoo_l6_loader_if.sv
// rtl/cuckoo_l6_loader_if.sv - request, index RAM, pattern RAM and status signals of the L6 loader
interface cuckoo_l6_loader_if;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_slot;
  logic [9:0]  req_a1;
  logic [9:0]  req_a2;
  logic [49:0] req_pattern;
  logic        clr;
  logic        idx_we;
  logic [10:0] idx_addr;
  logic [8:0]  idx_din;
  logic        pat_we;
  logic [8:0]  pat_addr;
  logic [49:0] pat_din;
  logic        busy;
  logic        done;
  logic        done_ok;
  logic [8:0]  fail_slot;
  logic [4:0]  kick_count;

  modport master (
    output req_valid, req_slot, req_a1, req_a2, req_pattern, clr,
    input  req_ready, idx_we, idx_addr, idx_din, pat_we, pat_addr, pat_din,
    input  busy, done, done_ok, fail_slot, kick_count
  );

  modport slave (
    input  req_valid, req_slot, req_a1, req_a2, req_pattern, clr,
    output req_ready, idx_we, idx_addr, idx_din, pat_we, pat_addr, pat_din,
    output busy, done, done_ok, fail_slot, kick_count
  );
endinterface

// File: rtl/cuckoo_l6_loader.sv
// rtl/cuckoo_l6_loader.sv - cuckoo insertion writer for the level-6 T1/T2 index and pattern RAMs
module cuckoo_l6_loader #(
  parameter int MAX_KICKS = 16
) (
  input  logic              clk,
  input  logic              rst,
  cuckoo_l6_loader_if.slave bus
);
  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WR_PAT, S_PROBE, S_KICK, S_DONE} state_t;

  localparam logic [4:0] LP_MAX = 5'(MAX_KICKS);

  state_t      r_state, w_state_n;
  logic [10:0] r_c;
  logic [8:0]  r_slot;
  logic [9:0]  r_a1, r_a2, r_addr;
  logic [49:0] r_pat;
  logic        r_tbl, r_ok;
  logic [4:0]  r_kicks;

  logic [1023:0] r_t1_v, r_t2_v;
  logic [8:0]    r_t1_s [1024];
  logic [8:0]    r_t2_s [1024];
  logic [9:0]    r_sa_a1 [512];
  logic [9:0]    r_sa_a2 [512];

  logic        w_kv;
  logic [8:0]  w_ks;
  logic [9:0]  w_kaddr;
  logic        w_mir_clr;
  logic        w_idx_we, w_pat_we, w_busy, w_ready, w_done;
  logic [10:0] w_idx_addr;
  logic [8:0]  w_idx_din;

  // Occupant of the bucket the current homeless slot is aiming at, and where it would go next.
  assign w_kv    = r_tbl ? r_t2_v[r_addr] : r_t1_v[r_addr];
  assign w_ks    = r_tbl ? r_t2_s[r_addr] : r_t1_s[r_addr];
  assign w_kaddr = r_tbl ? r_sa_a1[w_ks] : r_sa_a2[w_ks];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_CLEAR;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n  = r_state;
    w_idx_we   = 1'b0;
    w_idx_addr = '0;
    w_idx_din  = '0;
    w_pat_we   = 1'b0;
    w_mir_clr  = 1'b0;
    w_busy     = 1'b1;
    w_ready    = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_idx_we   = 1'b1;
        w_idx_addr = r_c;
        w_mir_clr  = 1'b1;
        if (r_c == 11'h7FF) w_state_n = S_IDLE;
      end
      S_IDLE: begin
        w_busy  = 1'b0;
        w_ready = 1'b1;
        if (bus.req_valid) w_state_n = S_WR_PAT;
        else if (bus.clr)  w_state_n = S_CLEAR;
      end
      S_WR_PAT: begin
        w_pat_we  = 1'b1;
        w_state_n = S_PROBE;
      end
      S_PROBE: begin
        w_idx_we  = 1'b1;
        w_idx_din = r_slot;
        if (!r_t1_v[r_a1]) begin
          w_idx_addr = {1'b0, r_a1};
          w_state_n  = S_DONE;
        end else if (!r_t2_v[r_a2]) begin
          w_idx_addr = {1'b1, r_a2};
          w_state_n  = S_DONE;
        end else begin
          w_idx_addr = {1'b0, r_a1};
          w_state_n  = S_KICK;
        end
      end
      S_KICK: begin
        if (!w_kv) begin
          w_idx_we   = 1'b1;
          w_idx_addr = {r_tbl, r_addr};
          w_idx_din  = r_slot;
          w_state_n  = S_DONE;
        end else if (r_kicks >= LP_MAX) begin
          w_state_n  = S_DONE;
        end else begin
          w_idx_we   = 1'b1;
          w_idx_addr = {r_tbl, r_addr};
          w_idx_din  = r_slot;
        end
      end
      S_DONE: begin
        w_done    = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_CLEAR;
    endcase
    if (rst) begin
      w_idx_we   = 1'b0;
      w_idx_addr = '0;
      w_idx_din  = '0;
      w_pat_we   = 1'b0;
      w_mir_clr  = 1'b0;
      w_ready    = 1'b0;
      w_done     = 1'b0;
      w_busy     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c     <= '0;
      r_slot  <= '0;
      r_a1    <= '0;
      r_a2    <= '0;
      r_pat   <= '0;
      r_addr  <= '0;
      r_tbl   <= 1'b0;
      r_ok    <= 1'b0;
      r_kicks <= '0;
    end else begin
      case (r_state)
        S_CLEAR: r_c <= r_c + 11'd1;
        S_IDLE: begin
          if (bus.req_valid) begin
            r_slot <= bus.req_slot;
            r_a1   <= bus.req_a1;
            r_a2   <= bus.req_a2;
            r_pat  <= bus.req_pattern;
          end else if (bus.clr) begin
            r_c <= '0;
          end
        end
        S_PROBE: begin
          if (!r_t1_v[r_a1] || !r_t2_v[r_a2]) begin
            r_ok    <= 1'b1;
            r_kicks <= '0;
          end else begin
            r_slot  <= r_t1_s[r_a1];
            r_tbl   <= 1'b1;
            r_addr  <= r_sa_a2[r_t1_s[r_a1]];
            r_kicks <= 5'd1;
          end
        end
        S_KICK: begin
          if (!w_kv) begin
            r_ok <= 1'b1;
          end else if (r_kicks >= LP_MAX) begin
            r_ok <= 1'b0;
          end else begin
            r_slot  <= w_ks;
            r_tbl   <= ~r_tbl;
            r_addr  <= w_kaddr;
            r_kicks <= (r_kicks == 5'd31) ? 5'd31 : r_kicks + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Mirrors track every index RAM write so placement never reads the shared RAMs.
  always_ff @(posedge clk) begin
    if (w_mir_clr) begin
      if (r_c[10]) r_t2_v[r_c[9:0]] <= 1'b0;
      else         r_t1_v[r_c[9:0]] <= 1'b0;
    end else if (w_idx_we) begin
      if (w_idx_addr[10]) begin
        r_t2_v[w_idx_addr[9:0]] <= 1'b1;
        r_t2_s[w_idx_addr[9:0]] <= w_idx_din;
      end else begin
        r_t1_v[w_idx_addr[9:0]] <= 1'b1;
        r_t1_s[w_idx_addr[9:0]] <= w_idx_din;
      end
    end
    if (w_pat_we) begin
      r_sa_a1[r_slot] <= r_a1;
      r_sa_a2[r_slot] <= r_a2;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.busy       = w_busy;
  assign bus.idx_we     = w_idx_we;
  assign bus.idx_addr   = w_idx_addr;
  assign bus.idx_din    = w_idx_din;
  assign bus.pat_we     = w_pat_we;
  assign bus.pat_addr   = w_pat_we ? r_slot : 9'd0;
  assign bus.pat_din    = w_pat_we ? r_pat : 50'd0;
  assign bus.done       = w_done;
  assign bus.done_ok    = w_done & r_ok;
  assign bus.fail_slot  = (w_done && !r_ok) ? r_slot : 9'd0;
  assign bus.kick_count = w_done ? r_kicks : 5'd0;
endmodule

// File: tb/tb_cuckoo_l6_loader.sv
// tb/tb_cuckoo_l6_loader.sv - directed bench for cuckoo_l6_loader (MAX_KICKS=2)
module tb_cuckoo_l6_loader;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  cuckoo_l6_loader_if bus ();

  cuckoo_l6_loader #(.MAX_KICKS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_check(input string tag);
    int bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (!(bus.idx_we === 1'b1 && bus.idx_addr === 11'(i) && bus.idx_din === 9'd0 &&
            bus.pat_we === 1'b0 && bus.req_ready === 1'b0))
        bad++;
      step();
    end
    chk(tag, 64'(bad), 64'd0);
    chk({tag, "_ready"}, bus.req_ready, 1);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic start(input logic [8:0] s, input logic [9:0] a1, input logic [9:0] a2,
                       input logic [49:0] p);
    chk("accept_ready", bus.req_ready, 1);
    bus.req_slot    = s;
    bus.req_a1      = a1;
    bus.req_a2      = a2;
    bus.req_pattern = p;
    bus.req_valid   = 1'b1;
    step();
    bus.req_valid   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.clr = 1'b0;
    bus.req_slot = '0;
    bus.req_a1 = '0;
    bus.req_a2 = '0;
    bus.req_pattern = '0;
    repeat (3) step();
    chk("rst_busy", bus.busy, 1);
    chk("rst_idx_we", bus.idx_we, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pat_we", bus.pat_we, 0);

    rst = 1'b0;
    #1;
    clear_check("init_clear");

    // slot 5 into empty tables
    start(9'd5, 10'h010, 10'h020, 50'h3_1234_5678_9ABC);
    chk("s5_pat_we", bus.pat_we, 1);
    chk("s5_pat_addr", bus.pat_addr, 5);
    chk("s5_pat_din", bus.pat_din, 50'h3_1234_5678_9ABC);
    chk("s5_t1_idx_we", bus.idx_we, 0);
    step();
    chk("s5_idx_we", bus.idx_we, 1);
    chk("s5_idx_addr", bus.idx_addr, 11'h010);
    chk("s5_idx_din", bus.idx_din, 5);
    chk("s5_t2_pat_we", bus.pat_we, 0);
    step();
    chk("s5_done", bus.done, 1);
    chk("s5_ok", bus.done_ok, 1);
    chk("s5_kicks", bus.kick_count, 0);
    chk("s5_ready_low", bus.req_ready, 0);
    step();
    chk("s5_idle", bus.req_ready, 1);
    chk("s5_done_low", bus.done, 0);

    // slot 6 collides in T1, lands in T2
    start(9'd6, 10'h010, 10'h033, 50'h0_0000_0000_0006);
    step();
    chk("s6_idx_addr", bus.idx_addr, 11'h433);
    chk("s6_idx_din", bus.idx_din, 6);
    step();
    chk("s6_done", bus.done, 1);
    chk("s6_ok", bus.done_ok, 1);
    chk("s6_kicks", bus.kick_count, 0);
    step();

    // slot 7 evicts slot 5 to its T2 bucket
    start(9'd7, 10'h010, 10'h033, 50'h0_0000_0000_0007);
    step();
    chk("s7_idx_addr", bus.idx_addr, 11'h010);
    chk("s7_idx_din", bus.idx_din, 7);
    step();
    chk("s7_kick_we", bus.idx_we, 1);
    chk("s7_kick_addr", bus.idx_addr, 11'h420);
    chk("s7_kick_din", bus.idx_din, 5);
    chk("s7_early_done", bus.done, 0);
    step();
    chk("s7_done", bus.done, 1);
    chk("s7_ok", bus.done_ok, 1);
    chk("s7_kicks", bus.kick_count, 1);
    step();

    // three slots sharing buckets: third insert fails
    start(9'd10, 10'h001, 10'h002, 50'h0_0000_0000_000A);
    step();
    chk("s10_idx_addr", bus.idx_addr, 11'h001);
    step();
    chk("s10_ok", bus.done_ok, 1);
    step();
    start(9'd11, 10'h001, 10'h002, 50'h0_0000_0000_000B);
    step();
    chk("s11_idx_addr", bus.idx_addr, 11'h402);
    step();
    chk("s11_ok", bus.done_ok, 1);
    step();
    start(9'd12, 10'h001, 10'h002, 50'h0_0000_0000_000C);
    step();
    chk("s12_idx_addr", bus.idx_addr, 11'h001);
    chk("s12_idx_din", bus.idx_din, 12);
    step();
    chk("s12_k1_addr", bus.idx_addr, 11'h402);
    chk("s12_k1_din", bus.idx_din, 10);
    chk("s12_k1_done", bus.done, 0);
    step();
    chk("s12_k2_no_we", bus.idx_we, 0);
    chk("s12_k2_done", bus.done, 0);
    chk("s12_k2_busy", bus.busy, 1);
    step();
    chk("s12_done", bus.done, 1);
    chk("s12_ok", bus.done_ok, 0);
    chk("s12_fail_slot", bus.fail_slot, 11);
    chk("s12_kicks", bus.kick_count, 2);
    step();
    chk("s12_idle", bus.req_ready, 1);

    // clr together with request and while busy: request wins, clr ignored
    bus.clr = 1'b1;
    start(9'd20, 10'h100, 10'h200, 50'h0_0000_0000_0014);
    chk("s20_pat_we", bus.pat_we, 1);
    step();
    chk("s20_idx_addr", bus.idx_addr, 11'h100);
    step();
    chk("s20_done", bus.done, 1);
    bus.clr = 1'b0;
    step();
    chk("busy_clr_ignored_busy", bus.busy, 0);
    chk("busy_clr_ignored_we", bus.idx_we, 0);
    chk("busy_clr_ignored_ready", bus.req_ready, 1);

    // clear from IDLE, then slot 5 is absent again
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    clear_check("idle_clear");
    start(9'd5, 10'h010, 10'h020, 50'h3_1234_5678_9ABC);
    step();
    chk("re5_idx_addr", bus.idx_addr, 11'h010);
    chk("re5_idx_din", bus.idx_din, 5);
    step();
    chk("re5_done", bus.done, 1);
    chk("re5_ok", bus.done_ok, 1);
    chk("re5_kicks", bus.kick_count, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
